// File: rtl/fpnew_pkg.sv
// Types shared across the FPU. The reorder buffer uses only the exception-flag struct.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_result_reorder.sv
// In-order completion buffer: entries are allocated at issue, written back by ID
// in any order, and retired strictly in allocation order.
module fpnew_result_reorder
    import fpnew_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 4,
    parameter type         TagType  = logic,
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  TagType              alloc_tag_i,
    output logic [IdxWidth-1:0] alloc_id_o,
    input  logic                wb_valid_i,
    output logic                wb_ready_o,
    input  logic [IdxWidth-1:0] wb_id_i,
    input  logic [Width-1:0]    wb_result_i,
    input  status_t             wb_status_i,
    input  logic                wb_ext_bit_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    result_o,
    output status_t             status_o,
    output logic                extension_bit_o,
    output TagType              tag_o,
    output logic                busy_o
);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    localparam logic [IdxWidth:0] FULL_COUNT = (IdxWidth + 1)'(Depth);

    entry_t                r_entry [Depth];
    logic [Depth-1:0]      r_alloc;
    logic [Depth-1:0]      r_done;
    logic [IdxWidth-1:0]   r_head;
    logic [IdxWidth-1:0]   r_tail;
    logic [IdxWidth:0]     r_count;

    logic w_alloc_hs;
    logic w_retire_hs;
    logic w_wb_target_alloc;
    logic w_wb_accept;

    assign alloc_ready_o = (r_count != FULL_COUNT);
    assign alloc_id_o    = r_tail;
    assign wb_ready_o    = 1'b1;
    assign busy_o        = (r_count != '0);

    assign out_valid_o     = r_alloc[r_head] & r_done[r_head];
    assign result_o        = r_entry[r_head].result;
    assign status_o        = r_entry[r_head].status;
    assign extension_bit_o = r_entry[r_head].ext_bit;
    assign tag_o           = r_entry[r_head].tag;

    assign w_alloc_hs  = alloc_valid_i & alloc_ready_o;
    assign w_retire_hs = out_valid_o & out_ready_i;

    // The slot being allocated this cycle counts as allocated so zero-latency
    // opgroups can complete in the same cycle they are issued.
    assign w_wb_target_alloc = r_alloc[wb_id_i] | (w_alloc_hs & (wb_id_i == r_tail));
    assign w_wb_accept       = wb_valid_i & w_wb_target_alloc & ~r_done[wb_id_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                r_entry[i] <= '0;
            end
            r_alloc <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_alloc <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc_hs) begin
                r_alloc[r_tail]     <= 1'b1;
                r_done[r_tail]      <= 1'b0;
                r_entry[r_tail].tag <= alloc_tag_i;
                r_tail              <= r_tail + 1'b1;
            end
            // Placed after allocation so a same-cycle writeback leaves done set.
            if (w_wb_accept) begin
                r_done[wb_id_i]          <= 1'b1;
                r_entry[wb_id_i].result  <= wb_result_i;
                r_entry[wb_id_i].status  <= wb_status_i;
                r_entry[wb_id_i].ext_bit <= wb_ext_bit_i;
            end
            if (w_retire_hs) begin
                r_alloc[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= r_count + (IdxWidth + 1)'(w_alloc_hs) - (IdxWidth + 1)'(w_retire_hs);
        end
    end

endmodule

// File: doc/fpnew_result_reorder.md
# fpnew_result_reorder

In-order completion buffer on the output side of the FPU's operation-group blocks. Issue logic allocates an entry and stamps the returned ID into the operation's tag. Opgroup blocks write results back by ID in any order, since their latencies differ. The block retires results strictly in allocation order through a valid/ready output port.

## Interface
Parameters:
- Width, 32, result width in bits.
- Depth, 4, number of entries; power of two, at least 2.
- TagType, logic, user tag carried from allocation to retirement.
- IdxWidth (localparam), $clog2(Depth), entry ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- alloc_valid_i  in  1  request a new entry.
- alloc_ready_o  out  1  an entry is free.
- alloc_tag_i  in  TagType  user tag stored in the entry.
- alloc_id_o  out  IdxWidth  ID of the entry allocated on this handshake; always equals the tail pointer.
- wb_valid_i  in  1  writeback strobe.
- wb_ready_o  out  1  constant 1.
- wb_id_i  in  IdxWidth  target entry of the writeback.
- wb_result_i  in  Width  writeback result.
- wb_status_i  in  fpnew_pkg::status_t  writeback exception flags.
- wb_ext_bit_i  in  1  writeback extension bit.
- flush_i  in  1  synchronous discard of all entries.
- out_valid_o  out  1  head entry is complete.
- out_ready_i  in  1  downstream accepts the head entry.
- result_o  out  Width  head entry result.
- status_o  out  fpnew_pkg::status_t  head entry flags.
- extension_bit_o  out  1  head entry extension bit.
- tag_o  out  TagType  head entry tag.
- busy_o  out  1  at least one entry is allocated.

## Operation
- Storage is a circular buffer with these registers:
  - head and tail pointers, IdxWidth bits each.
  - count, IdxWidth+1 bits.
  - per entry: alloc bit, done bit, result, status, ext_bit, tag.
- Allocation occurs when alloc_valid_i and alloc_ready_o are both high.
  - Write the tag into entry[tail]; set alloc=1 and done=0.
  - Increment tail modulo Depth (wraps Depth-1 to 0).
- alloc_ready_o = (count != Depth). It depends only on registered state and has no path from out_ready_i. When the buffer is full, allocation stalls even if a retire happens in the same cycle.
- Writeback occurs when wb_valid_i is high.
  - Store result, status and ext_bit into entry[wb_id_i] and set done=1.
  - The writeback is silently ignored if the entry is not allocated or is already done.
  - Exception: the entry being allocated in the same cycle counts as allocated. This supports zero-latency opgroups, and that entry ends the cycle with done=1.
- Retirement:
  - out_valid_o = alloc[head] & done[head].
  - The data outputs show entry[head] at all times; their value is don't-care while out_valid_o is low.
  - On the out_valid_o/out_ready_i handshake, clear alloc and done of the head entry and increment head modulo Depth.
- count updates as count + alloc_handshake - retire_handshake. Simultaneous allocation and retirement leaves count unchanged.
- Flush:
  - Clear every alloc and done bit; set head, tail and count to 0.
  - Flush has priority over allocation, writeback and retirement in the same cycle. None of them takes effect.
  - A writeback that arrives after the flush for a stale ID is dropped by the unallocated-entry rule above.
- busy_o = (count != 0).

## Timing
- Reset values:
  - alloc_ready_o=1, alloc_id_o=0, out_valid_o=0, busy_o=0, wb_ready_o=1.
  - All entry bits are 0; data outputs are 0.
- Latency is 1 cycle from writeback to out_valid_o. There is no bypass: out_valid_o is a function of registers only.
- Throughput is one allocation, one writeback and one retirement per cycle, all simultaneously.
- A writeback to a non-head entry becomes visible once all older entries have retired.
- After a flush in cycle N: out_valid_o=0, busy_o=0 and alloc_id_o=0 in cycle N+1.
- Reset asserted mid-operation returns the block to reset values immediately (asynchronous reset).

## Structure
- Single module with a flop-array entry store; no sub-module.
- The entry struct is declared locally; it depends on the Width and TagType parameters.
- Use fpnew_pkg::status_t from the shared package; no new package types are needed.

## Test plan
- Allocate IDs 0,1,2 with tags 5,6,7; write back 2,1,0 with results 0xC,0xB,0xA. Required: retires (0xA,5), (0xB,6), (0xC,7) in order; no output before the writeback to ID 0 plus 1 cycle.
- Fill Depth=4 entries. Required: alloc_ready_o drops. Hold alloc_valid_i high while retiring the head: no allocation that cycle, and alloc_ready_o rises the next cycle.
- Run 10 in-order operations through Depth=4. Required: alloc_id_o wraps 3->0 and results retire in issue order.
- Allocate and write back the same ID in one cycle. Required: out_valid_o=1 next cycle with that result.
- Allocate 3 entries, then assert flush_i together with a writeback to ID 0. Required: next cycle busy_o=0 and out_valid_o=0. A later writeback to ID 1 is ignored.
- Write back an unallocated ID, then write back an already-done ID with new data. Required: both are ignored and the retired data is the original.
